// File: rtl/imc_wl_sequencer_pkg.sv
// Shared types for the wordline command sequencer: row address width, command opcodes,
// sequencer FSM states and a small opcode helper.
package imc_pkg;

  localparam int unsigned ADDR_W = 7;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_COMPUTE = 2'b11
  } imc_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_DONE
  } seq_state_e;

  // Ops that drive read port 1 and strobe the sense amps.
  function automatic logic op_reads(imc_op_e op);
    return (op == OP_READ) || (op == OP_COMPUTE);
  endfunction

endpackage

// File: rtl/imc_wl_sequencer_if.sv
// Command handshake between an upstream requester (master) and the sequencer (slave).
interface imc_wl_sequencer_if;
  import imc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  imc_op_e           cmd_op;
  logic [ADDR_W-1:0] cmd_addr_a;
  logic [ADDR_W-1:0] cmd_addr_b;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr_a,
    output cmd_addr_b,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr_a,
    input  cmd_addr_b,
    output cmd_ready
  );

endinterface

// File: rtl/imc_wl_sequencer.sv
// Command sequencer for the 128-row dual-read/single-write wordline decoder.
// Each accepted READ/WRITE/COMPUTE runs IDLE -> PRE -> ACT (SETTLE_CYC cycles) -> DONE.
// PRE keeps every enable low so a write can never overlap a read of the previous access.
// All decoder-facing outputs are registered. Optional feature macro: IMC_SAME_ROW_CHECK_EN
// (reject COMPUTE with identical rows via a cmd_err pulse); undefined ties cmd_err to 0.
module imc_wl_sequencer
  import imc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  imc_wl_sequencer_if.slave bus,
  output logic [ADDR_W-1:0] read_address1,
  output logic [ADDR_W-1:0] read_address2,
  output logic              read_enable1,
  output logic              read_enable2,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_enable,
  output logic              sense_en,
  output logic              done,
  output logic              cmd_err
);

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYC - 1);

  seq_state_e        state_q;
  imc_op_e           op_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              re1_q;
  logic              re2_q;
  logic              we_q;
  logic              sense_q;
  logic              done_q;
  logic [ADDR_W-1:0] ra1_q;
  logic [ADDR_W-1:0] ra2_q;
  logic [ADDR_W-1:0] wa_q;

  logic accept;
  logic same_row_reject;

  assign accept = bus.cmd_valid && ready_q;

`ifdef IMC_SAME_ROW_CHECK_EN
  assign same_row_reject = (bus.cmd_op == OP_COMPUTE) && (bus.cmd_addr_a == bus.cmd_addr_b);
`else
  assign same_row_reject = 1'b0;
`endif

  // Sequencer FSM; every decoder output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      re1_q   <= 1'b0;
      re2_q   <= 1'b0;
      we_q    <= 1'b0;
      sense_q <= 1'b0;
      done_q  <= 1'b0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa_q    <= '0;
    end else begin
      sense_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        // DONE accepts like IDLE so back-to-back commands lose no cycle.
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          op_q    <= OP_NOP;
          ready_q <= 1'b1;
          ra1_q   <= '0;
          ra2_q   <= '0;
          wa_q    <= '0;
          if (accept && !same_row_reject) begin
            unique case (bus.cmd_op)
              OP_READ: begin
                state_q <= S_PRE;
                op_q    <= OP_READ;
                ready_q <= 1'b0;
                ra1_q   <= bus.cmd_addr_a;
              end
              OP_WRITE: begin
                state_q <= S_PRE;
                op_q    <= OP_WRITE;
                ready_q <= 1'b0;
                wa_q    <= bus.cmd_addr_a;
              end
              OP_COMPUTE: begin
                state_q <= S_PRE;
                op_q    <= OP_COMPUTE;
                ready_q <= 1'b0;
                ra1_q   <= bus.cmd_addr_a;
                ra2_q   <= bus.cmd_addr_b;
              end
              default: ;  // NOP is consumed with no effect
            endcase
          end
        end
        S_PRE: begin
          state_q <= S_ACT;
          cnt_q   <= CntLoad;
          re1_q   <= op_reads(op_q);
          re2_q   <= (op_q == OP_COMPUTE);
          we_q    <= (op_q == OP_WRITE);
          sense_q <= (CntLoad == 4'd0) && op_reads(op_q);
        end
        S_ACT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_DONE;
            re1_q   <= 1'b0;
            re2_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            // Strobe sense on the cycle the counter will read zero: the last ACT cycle.
            sense_q <= (cnt_q == 4'd1) && op_reads(op_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef IMC_SAME_ROW_CHECK_EN
  logic err_q;

  // One-cycle reject pulse for a same-row COMPUTE; the FSM stays in IDLE for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && same_row_reject;
    end
  end

  assign cmd_err = err_q;
`else
  assign cmd_err = 1'b0;
`endif

  assign bus.cmd_ready  = ready_q;
  assign read_address1  = ra1_q;
  assign read_address2  = ra2_q;
  assign write_address  = wa_q;
  assign read_enable1   = re1_q;
  assign read_enable2   = re2_q;
  assign write_enable   = we_q;
  assign sense_en       = sense_q;
  assign done           = done_q;

endmodule

// File: tb/tb_imc_wl_sequencer.sv
// Scoreboard bench for imc_wl_sequencer: the driver pushes the expected access for every
// accepted command; a negedge monitor pops it when the DUT enters ACT (or pulses cmd_err)
// and checks enables, addresses, sense timing, done timing and the PRE gap.
module tb_imc_wl_sequencer;
  import imc_pkg::*;

  localparam int S = 2;

  typedef struct {
    logic       err;
    logic       re1;
    logic       re2;
    logic       we;
    logic [6:0] ra1;
    logic [6:0] ra2;
    logic [6:0] wa;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] read_address1;
  logic [6:0] read_address2;
  logic [6:0] write_address;
  logic       read_enable1;
  logic       read_enable2;
  logic       write_enable;
  logic       sense_en;
  logic       done;
  logic       cmd_err;

  imc_wl_sequencer_if bus ();

  imc_wl_sequencer #(
    .SETTLE_CYC(S)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .read_address1(read_address1),
    .read_address2(read_address2),
    .read_enable1 (read_enable1),
    .read_enable2 (read_enable2),
    .write_address(write_address),
    .write_enable (write_enable),
    .sense_en     (sense_en),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  int   n_checks = 0;
  int   n_fails = 0;
  int   cyc = 0;
  int   outstanding = 0;
  int   act_idx = -1;
  exp_t sb[$];
  exp_t cur;
  logic prev_en = 1'b0;
  logic [20:0] prev_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(imc_op_e op, logic [6:0] a, logic [6:0] b, int acc);
    exp_t e;
    logic same;
    e     = '{err: 1'b0, re1: 1'b0, re2: 1'b0, we: 1'b0, ra1: '0, ra2: '0, wa: '0, acc: acc};
    same  = (a == b);
`ifndef IMC_SAME_ROW_CHECK_EN
    same  = 1'b0;
`endif
    case (op)
      OP_READ: begin
        e.re1 = 1'b1;
        e.ra1 = a;
      end
      OP_WRITE: begin
        e.we = 1'b1;
        e.wa = a;
      end
      OP_COMPUTE: begin
        if (same) begin
          e.err = 1'b1;
        end else begin
          e.re1 = 1'b1;
          e.re2 = 1'b1;
          e.ra1 = a;
          e.ra2 = b;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic send(input imc_op_e op, input logic [6:0] a, input logic [6:0] b,
                      output int acc);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check_eq("ready_timeout", 32'(bus.cmd_ready), 32'd1);
      acc = -1;
      return;
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_addr_a = a;
    bus.cmd_addr_b = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    acc           = cyc;
    if (op != OP_NOP) begin
      sb.push_back(make_exp(op, a, b, acc));
      outstanding++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (outstanding != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_outstanding", 32'(outstanding), 32'd0);
  endtask

  // Monitor: pops scoreboard entries on ACT entry / reject pulse and checks each cycle.
  always @(negedge clk) begin
    logic [27:0] obs;
    logic [27:0] expv;
    logic        en;
    exp_t        e;
    if (rst) begin
      act_idx     = -1;
      prev_en     = 1'b0;
      outstanding = 0;
      sb.delete();
    end else begin
      en  = read_enable1 | read_enable2 | write_enable;
      obs = {cmd_err, read_enable1, read_enable2, write_enable, read_address1, read_address2,
             write_address, sense_en, done, bus.cmd_ready};
      check_eq("rw_exclusive", 32'(read_enable1 & write_enable), 32'd0);
      if (cmd_err) begin
        check_eq("err_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("err_kind", 32'(e.err), 32'd1);
          check_eq("err_latency", 32'(cyc - e.acc), 32'd0);
          check_eq("err_ready", 32'(bus.cmd_ready), 32'd1);
          outstanding--;
        end
      end
      if (act_idx == S) begin
        expv = {1'b0, 3'b000, cur.ra1, cur.ra2, cur.wa, 1'b0, 1'b1, 1'b1};
        check_eq("done_cycle", 32'(obs), 32'(expv));
        check_eq("done_latency", 32'(cyc - cur.acc), 32'(S + 1));
        act_idx = -1;
        outstanding--;
      end else if (act_idx >= 0 || en) begin
        if (act_idx < 0) begin
          check_eq("act_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            cur     = sb.pop_front();
            act_idx = 0;
            check_eq("pre_gap", 32'(prev_en), 32'd0);
            check_eq("pre_addr", 32'(prev_addr), 32'({cur.ra1, cur.ra2, cur.wa}));
            check_eq("act_latency", 32'(cyc - cur.acc), 32'd1);
          end
        end else begin
          act_idx++;
        end
        if (act_idx >= 0) begin
          expv = {cur.err, cur.re1, cur.re2, cur.we, cur.ra1, cur.ra2, cur.wa,
                  cur.re1 && (act_idx == S - 1), 1'b0, 1'b0};
          check_eq("act_cycle", 32'(obs), 32'(expv));
          if (act_idx == S - 1) act_idx = S;
        end
      end else begin
        check_eq("idle_strobes", 32'({sense_en, done}), 32'd0);
      end
      prev_en   = en;
      prev_addr = {read_address1, read_address2, write_address};
    end
  end

  initial begin
    int acc;
    int a1;
    int a2;
    int n;
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = OP_NOP;
    bus.cmd_addr_a = '0;
    bus.cmd_addr_b = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_strobes", 32'({read_enable1, read_enable2, write_enable, sense_en, done,
                                 cmd_err}), 32'd0);
    check_eq("rst_addrs", 32'({read_address1, read_address2, write_address}), 32'd0);
    check_eq("rst_ready", 32'(bus.cmd_ready), 32'd1);

    send(OP_READ, 7'd5, 7'd0, acc);
    wait_idle();

    send(OP_WRITE, 7'd127, 7'd0, a1);
    send(OP_READ, 7'd0, 7'd0, a2);
    check_eq("b2b_throughput", 32'(a2 - a1), 32'(S + 2));
    wait_idle();

    send(OP_COMPUTE, 7'd3, 7'd64, acc);
    wait_idle();

    send(OP_COMPUTE, 7'd9, 7'd9, acc);
    wait_idle();

    send(OP_NOP, 7'd11, 7'd12, acc);
    @(negedge clk);
    check_eq("nop_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("nop_no_enable", 32'({read_enable1, read_enable2, write_enable}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      send(imc_op_e'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
           7'($urandom_range(0, 127)), acc);
    end
    wait_idle();

    // Reset in the middle of a WRITE's ACT window.
    send(OP_WRITE, 7'd42, 7'd0, acc);
    n = 0;
    while (!write_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("write_act_seen", 32'(write_enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_drop", 32'({read_enable1, read_enable2, write_enable, sense_en, done}),
             32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
